// File: rtl/ct_pt_add_seq_pkg.sv
// Shared types and default geometry for the ciphertext + plaintext slot-serial adder.
// Slot 0 of every polynomial sits in the least-significant word of its packed array.
package ct_pt_add_seq_pkg;

  localparam int unsigned N_SLOTS_L = 4;
  localparam int unsigned W_BITS_L  = 8;
  localparam int unsigned Q_MOD_L   = 17;
  localparam int unsigned DELTA_L   = 4;

  typedef logic [W_BITS_L-1:0] word_t;
  typedef word_t [N_SLOTS_L-1:0] PT_t;

  typedef struct packed {
    PT_t a;
    PT_t b;
  } CT_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/ct_pt_add_lane.sv
// One-slot modular add: r = (b + DELTA*g) mod Q with a single conditional subtract.
// Caller guarantees b < Q and DELTA*g < Q, so one subtract always suffices.
module ct_pt_add_lane #(
  parameter int unsigned W     = 8,
  parameter int unsigned Q     = 17,
  parameter int unsigned DELTA = 4
) (
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] g_i,
  output logic [W-1:0] r_o
);

  logic [2*W-1:0] dg;
  logic [2*W:0]   sum;
  logic [2*W:0]   q_ext;

  assign q_ext = (2*W+1)'(Q);
  assign dg    = (2*W)'(DELTA) * (2*W)'(g_i);
  assign sum   = (2*W+1)'(b_i) + (2*W+1)'(dg);
  assign r_o   = (sum >= q_ext) ? W'(sum - q_ext) : sum[W-1:0];

endmodule

// File: rtl/ct_pt_add_seq.sv
// Slot-serial ct + pt adder: captures one ciphertext and plaintext, adds DELTA*gamma into
// the B polynomial LANES slots per cycle, then holds the result until the consumer takes it.
module ct_pt_add_seq
  import ct_pt_add_seq_pkg::*;
#(
  parameter int unsigned N      = N_SLOTS_L,
  parameter int unsigned W      = W_BITS_L,
  parameter int unsigned LANES  = 1,
  parameter int unsigned QP     = Q_MOD_L,
  parameter int unsigned DELTAP = DELTA_L
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  CT_t  in_ct,
  input  PT_t  in_gamma,
  output logic out_valid,
  input  logic out_ready,
  output CT_t  out_ct,
  output logic busy
);

  localparam int unsigned IDX_W  = $clog2(N) + 1;
  localparam int unsigned SLOT_W = $clog2(N);

  if (LANES == 0 || (N % LANES) != 0) begin : g_bad_lanes
    $error("ct_pt_add_seq: N (%0d) must be a non-zero multiple of LANES (%0d)", N, LANES);
  end
  if (N != N_SLOTS_L || W != W_BITS_L) begin : g_bad_geom
    $error("ct_pt_add_seq: N/W must match the package CT_t/PT_t geometry");
  end

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  CT_t               out_ct_q, out_ct_d;
  PT_t               gamma_q, gamma_d;

  logic [SLOT_W-1:0] slot   [LANES];
  word_t             lane_b [LANES];
  word_t             lane_g [LANES];
  word_t             lane_r [LANES];

  // Lane j always works on slot idx+j; the read side is a plain idx-indexed mux.
  for (genvar gi = 0; gi < int'(LANES); gi++) begin : g_lane
    assign slot[gi]   = idx_q[SLOT_W-1:0] + SLOT_W'(gi);
    assign lane_b[gi] = out_ct_q.b[slot[gi]];
    assign lane_g[gi] = gamma_q[slot[gi]];

    ct_pt_add_lane #(
      .W     (W),
      .Q     (QP),
      .DELTA (DELTAP)
    ) u_lane (
      .b_i (lane_b[gi]),
      .g_i (lane_g[gi]),
      .r_o (lane_r[gi])
    );
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    out_ct_d = out_ct_q;
    gamma_d  = gamma_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_ct_d = in_ct;
          gamma_d  = in_gamma;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < int'(LANES); j++) begin
          out_ct_d.b[slot[j]] = lane_r[j];
        end
        idx_d = idx_q + IDX_W'(LANES);
        if (idx_d == IDX_W'(N)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      out_ct_q <= '0;
      gamma_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      out_ct_q <= out_ct_d;
      gamma_q  <= gamma_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state_q == DONE);
  assign out_ct    = out_ct_q;

endmodule

// File: tb/tb_ct_pt_add_seq.sv
// Directed bench for ct_pt_add_seq: a LANES=1 and a LANES=2 instance, N=4, W=8, q=17, DELTA=4.
module tb_ct_pt_add_seq;
  import ct_pt_add_seq_pkg::*;

  logic clk;
  logic rst_n;
  CT_t  in_ct;
  PT_t  in_gamma;
  logic in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  CT_t  out_ct1, out_ct2;

  int n_chk;
  int n_fail;

  ct_pt_add_seq #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_ct(in_ct), .in_gamma(in_gamma), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_ct(out_ct1), .busy(busy1)
  );

  ct_pt_add_seq #(.LANES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_ct(in_ct), .in_gamma(in_gamma), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_ct(out_ct2), .busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    string name;
    CT_t   ct;
    PT_t   g;
    PT_t   exp_b;
  } vec_t;

  vec_t vecs[5];

  function automatic PT_t mk(input int e0, input int e1, input int e2, input int e3);
    PT_t p;
    p[0] = 8'(e0);
    p[1] = 8'(e1);
    p[2] = 8'(e2);
    p[3] = 8'(e3);
    return p;
  endfunction

  function automatic CT_t mkct(input PT_t a, input PT_t b);
    CT_t c;
    c.a = a;
    c.b = b;
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic get_ov(input int sel);
    return (sel != 0) ? out_valid2 : out_valid1;
  endfunction
  function automatic logic get_ir(input int sel);
    return (sel != 0) ? in_ready2 : in_ready1;
  endfunction
  function automatic CT_t get_ct(input int sel);
    return (sel != 0) ? out_ct2 : out_ct1;
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel != 0) in_valid2 = v; else in_valid1 = v;
  endtask
  task automatic set_ready(input int sel, input logic v);
    if (sel != 0) out_ready2 = v; else out_ready1 = v;
  endtask

  // Waits (bounded) for out_valid; returns clock edges seen since the accepting edge.
  task automatic wait_out(input int sel, output int lat);
    lat = 0;
    while (!get_ov(sel) && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input int sel, input CT_t ct, input PT_t g, input PT_t exp_b,
                        input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    chk({name, "_in_ready"}, 64'(get_ir(sel)), 64'd1);
    in_ct    = ct;
    in_gamma = g;
    set_valid(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(sel, 1'b0);
    chk({name, "_busy_after_accept"}, 64'(get_ir(sel)), 64'd0);
    wait_out(sel, lat);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_B"}, 64'(get_ct(sel).b), 64'(exp_b));
    chk({name, "_A"}, 64'(get_ct(sel).a), 64'(ct.a));
    set_ready(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ready(sel, 1'b0);
    chk({name, "_out_valid_drop"}, 64'(get_ov(sel)), 64'd0);
    chk({name, "_in_ready_back"}, 64'(get_ir(sel)), 64'd1);
  endtask

  initial begin
    PT_t a1, b1, g1, e1, b2, g2, e2;
    int  lat;
    n_chk  = 0;
    n_fail = 0;

    a1 = mk(5, 6, 7, 8);
    b1 = mk(3, 16, 0, 10);  g1 = mk(1, 0, 3, 1);  e1 = mk(7, 16, 12, 14);
    b2 = mk(16, 9, 13, 0);  g2 = mk(2, 2, 1, 0);  e2 = mk(7, 0, 0, 0);
    vecs[0] = '{"basic", mkct(a1, b1), g1, e1};
    vecs[1] = '{"wrap", mkct(mk(1, 2, 3, 4), b2), g2, e2};
    vecs[2] = '{"all_wrap", mkct(mk(9, 9, 9, 9), mk(16, 16, 16, 16)), mk(4, 4, 4, 4), mk(15, 15, 15, 15)};
    vecs[3] = '{"zero_gamma", mkct(mk(255, 0, 128, 1), mk(0, 1, 2, 3)), mk(0, 0, 0, 0), mk(0, 1, 2, 3)};
    vecs[4] = '{"mixed", mkct(mk(11, 22, 33, 44), mk(12, 5, 16, 8)), mk(3, 1, 0, 2), mk(7, 9, 16, 16)};

    clk = 1'b0;
    rst_n = 1'b0;
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    out_ready1 = 1'b0; out_ready2 = 1'b0;
    in_ct = '0;
    in_gamma = '0;
    #1;
    chk("reset_out_valid", 64'(out_valid1), 64'd0);
    chk("reset_in_ready", 64'(in_ready1), 64'd1);
    chk("reset_busy", 64'(busy1), 64'd0);
    chk("reset_out_ct", 64'(out_ct1), 64'd0);
    chk("reset_out_valid_l2", 64'(out_valid2), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors on the single-lane instance.
    for (int i = 0; i < 5; i++) begin
      run_op(0, vecs[i].ct, vecs[i].g, vecs[i].exp_b, 4, vecs[i].name);
    end

    // Two-lane instance: same results, half the latency.
    run_op(1, vecs[0].ct, vecs[0].g, vecs[0].exp_b, 2, "lanes2_basic");
    run_op(1, vecs[1].ct, vecs[1].g, vecs[1].exp_b, 2, "lanes2_wrap");

    // Backpressure: result held and new requests ignored while DONE is stalled.
    @(negedge clk);
    in_ct = vecs[0].ct; in_gamma = vecs[0].g; in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    wait_out(0, lat);
    chk("bp_latency", 64'(lat), 64'd4);
    for (int k = 0; k < 5; k++) begin
      in_valid1 = 1'b1;
      in_ct = vecs[1].ct; in_gamma = vecs[1].g;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold_valid_%0d", k), 64'(out_valid1), 64'd1);
      chk($sformatf("bp_hold_in_ready_%0d", k), 64'(in_ready1), 64'd0);
      chk($sformatf("bp_hold_ct_%0d", k), 64'(out_ct1), 64'(mkct(a1, e1)));
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("bp_release_valid", 64'(out_valid1), 64'd0);
    repeat (3) @(negedge clk);
    chk("bp_no_capture", 64'(busy1), 64'd0);

    // Reset two cycles into RUN discards the operation.
    @(negedge clk);
    in_ct = vecs[1].ct; in_gamma = vecs[1].g; in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_mid_out_ct", 64'(out_ct1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", 64'(out_valid1), 64'd0);
    run_op(0, vecs[0].ct, vecs[0].g, vecs[0].exp_b, 4, "after_reset");

    // Back-to-back: in_valid held high; second accept one cycle after the out handshake.
    @(negedge clk);
    in_ct = vecs[0].ct; in_gamma = vecs[0].g; in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_ct = vecs[1].ct; in_gamma = vecs[1].g;
    wait_out(0, lat);
    chk("b2b_first_latency", 64'(lat), 64'd4);
    chk("b2b_first_ct", 64'(out_ct1), 64'(vecs[0].ct.a) << 32 | 64'(e1));
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("b2b_gap_in_ready", 64'(in_ready1), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_second_accepted", 64'(busy1), 64'd1);
    in_valid1 = 1'b0;
    wait_out(0, lat);
    chk("b2b_second_latency", 64'(lat), 64'd4);
    chk("b2b_second_ct", 64'(out_ct1), 64'(mkct(vecs[1].ct.a, e2)));
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("b2b_done", 64'(out_valid1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
